// File: rtl/ws2811_rx.sv
// WS2811/WS2812 single-wire receiver: decodes DI pulse widths into 24-bit GRB pixels,
// indexes them within a frame and reports the latch gap as end-of-frame.
module ws2811_rx #(
    parameter int SYSTEM_CLOCK = 50_000_000,
    parameter int MAX_LEDS     = 8,
    parameter int ADDR_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  DI,
    output logic                  pixel_valid,
    output logic [ADDR_WIDTH-1:0] pixel_address,
    output logic [7:0]            green_out,
    output logic [7:0]            red_out,
    output logic [7:0]            blue_out,
    output logic                  frame_done,
    output logic [ADDR_WIDTH:0]   frame_pixels,
    output logic                  overflow,
    output logic                  bit_error
);

    localparam int CYCLE_COUNT  = SYSTEM_CLOCK / 800000;
    localparam int THRESH       = CYCLE_COUNT / 2;
    localparam int MIN_HIGH     = CYCLE_COUNT / 10;
    localparam int RESET_DETECT = SYSTEM_CLOCK / 20000;

    localparam int HW = $clog2(CYCLE_COUNT + 1);
    localparam int LW = $clog2(RESET_DETECT + 1);

    localparam logic [HW-1:0]       H_LAST   = HW'(CYCLE_COUNT - 1);
    localparam logic [HW-1:0]       H_THRESH = HW'(THRESH);
    localparam logic [HW-1:0]       H_MIN    = HW'(MIN_HIGH);
    localparam logic [LW-1:0]       L_LAST   = LW'(RESET_DETECT - 1);
    localparam logic [ADDR_WIDTH:0] PIX_MAX  = (ADDR_WIDTH + 1)'(MAX_LEDS);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } state_e;

    state_e                state_q;
    logic                  sync1_q;
    logic                  ds_q;
    logic                  ds_prev_q;
    logic [HW-1:0]         h_cnt_q;
    logic [LW-1:0]         l_cnt_q;
    logic [4:0]            bit_cnt_q;
    logic [22:0]           shift_q;
    logic [ADDR_WIDTH:0]   pix_idx_q;

    logic                  pixel_valid_q;
    logic [ADDR_WIDTH-1:0] pixel_address_q;
    logic [7:0]            green_q;
    logic [7:0]            red_q;
    logic [7:0]            blue_q;
    logic                  frame_done_q;
    logic [ADDR_WIDTH:0]   frame_pixels_q;
    logic                  overflow_q;
    logic                  bit_error_q;

    logic                  rise;
    logic                  bit_d;
    logic [23:0]           word_d;

    always_comb begin
        rise   = ds_q & ~ds_prev_q;
        bit_d  = (h_cnt_q > H_THRESH);
        word_d = {shift_q, bit_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= SYNC;
            sync1_q         <= 1'b0;
            ds_q            <= 1'b0;
            ds_prev_q       <= 1'b0;
            h_cnt_q         <= '0;
            l_cnt_q         <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            pix_idx_q       <= '0;
            pixel_valid_q   <= 1'b0;
            pixel_address_q <= '0;
            green_q         <= '0;
            red_q           <= '0;
            blue_q          <= '0;
            frame_done_q    <= 1'b0;
            frame_pixels_q  <= '0;
            overflow_q      <= 1'b0;
            bit_error_q     <= 1'b0;
        end else begin
            sync1_q       <= DI;
            ds_q          <= sync1_q;
            ds_prev_q     <= ds_q;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            bit_error_q   <= 1'b0;

            unique case (state_q)
                // Wait for a full latch gap so decoding never starts mid-frame.
                SYNC: begin
                    if (ds_q) begin
                        l_cnt_q <= '0;
                    end else if (l_cnt_q == L_LAST) begin
                        l_cnt_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        l_cnt_q <= l_cnt_q + 1'b1;
                    end
                end

                IDLE: begin
                    if (rise) begin
                        state_q    <= HIGH;
                        h_cnt_q    <= HW'(1);
                        bit_cnt_q  <= '0;
                        pix_idx_q  <= '0;
                        overflow_q <= 1'b0;
                    end
                end

                HIGH: begin
                    if (ds_q) begin
                        if (h_cnt_q == H_LAST) begin
                            bit_error_q <= 1'b1;
                            l_cnt_q     <= '0;
                            state_q     <= SYNC;
                        end else begin
                            h_cnt_q <= h_cnt_q + 1'b1;
                        end
                    end else if (h_cnt_q < H_MIN) begin
                        bit_error_q <= 1'b1;
                        l_cnt_q     <= '0;
                        state_q     <= SYNC;
                    end else begin
                        shift_q <= word_d[22:0];
                        l_cnt_q <= LW'(1);
                        state_q <= LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_q <= '0;
                            if (pix_idx_q < PIX_MAX) begin
                                pixel_valid_q   <= 1'b1;
                                pixel_address_q <= pix_idx_q[ADDR_WIDTH-1:0];
                                green_q         <= word_d[23:16];
                                red_q           <= word_d[15:8];
                                blue_q          <= word_d[7:0];
                                pix_idx_q       <= pix_idx_q + 1'b1;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                LOW: begin
                    if (ds_q) begin
                        h_cnt_q <= HW'(1);
                        state_q <= HIGH;
                    end else if (l_cnt_q == L_LAST) begin
                        frame_done_q   <= 1'b1;
                        frame_pixels_q <= pix_idx_q;
                        if (bit_cnt_q != 5'd0) begin
                            bit_error_q <= 1'b1;
                        end
                        bit_cnt_q <= '0;
                        l_cnt_q   <= '0;
                        state_q   <= IDLE;
                    end else begin
                        l_cnt_q <= l_cnt_q + 1'b1;
                    end
                end

                default: state_q <= SYNC;
            endcase
        end
    end

    assign pixel_valid   = pixel_valid_q;
    assign pixel_address = pixel_address_q;
    assign green_out     = green_q;
    assign red_out       = red_q;
    assign blue_out      = blue_q;
    assign frame_done    = frame_done_q;
    assign frame_pixels  = frame_pixels_q;
    assign overflow      = overflow_q;
    assign bit_error     = bit_error_q;

endmodule
